mem_ctrl_arb: RTL

- Two-requester controller in front of the single-port 64-word `mem` table used by the knapsack DP datapath.
- Port A is the host/loader (item weights/values); port B is the DP engine.
- Arbitrates one access per cycle, range-checks addresses, drives the registered `mem` interface and routes read data back with a fixed latency.
- Provides a hardware table-clear sweep that runs before each solve.

---
 rtl/mem_ctrl_arb_pkg.sv | 11 +
 rtl/mem_ctrl_arb_rr_arb2.sv | 28 ++
 rtl/mem_ctrl_arb.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_ctrl_arb_pkg.sv
// mem_ctrl_pkg: shared types and constants for the mem_ctrl_arb controller and its arbiter.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;
  typedef enum logic {PORT_A, PORT_B} port_e;
  typedef struct packed {
    logic  valid;
    port_e port;
    logic  oor;
  } rd_tag_t;
  localparam int RD_LAT = 2;
endpackage

// File: rtl/mem_ctrl_arb_rr_arb2.sv
// rr_arb2: two-input grant (round-robin, or A-first when MEM_ARB_FIXED_PRIO_EN is defined).
// Ports: clk, rst_n (async active-low), en (grants allowed), a_req/b_req in, a_gnt/b_gnt out (combinational).
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);
`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign a_gnt = en && a_req;
  assign b_gnt = en && b_req && !a_req;
`else
  import mem_ctrl_pkg::*;
  port_e rr_last_q, rr_last_d;
  // On contention the port that did not win last time is served.
  assign a_gnt = en && a_req && (!b_req || rr_last_q == PORT_B);
  assign b_gnt = en && b_req && (!a_req || rr_last_q == PORT_A);
  always_comb rr_last_d = a_gnt ? PORT_A : b_gnt ? PORT_B : rr_last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_last_q <= PORT_B;
    else rr_last_q <= rr_last_d;
`endif
endmodule

// File: rtl/mem_ctrl_arb.sv
// mem_ctrl_arb: two-port arbiter/controller for the 64-word mem table, with a clear sweep.
// Ports: clk, rst_n (async active-low); clr_start/clr_done/busy sweep control;
// a_*/b_* request ports (req, we, addr, wdata -> gnt, rvalid, rdata, err);
// mem_addr/mem_rd_en/mem_wr_en/mem_wdata registered to mem, mem_rdata back from mem.
// Build option: MEM_ARB_FIXED_PRIO_EN makes port A win every contention.
module mem_ctrl_arb #(
  parameter int                MEM_DEPTH = 64,
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  output logic              clr_done,
  output logic              busy,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mem_ctrl_pkg::*;
  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       sweep_q, sweep_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    mem_rd_en_q, mem_rd_en_d, mem_wr_en_q, mem_wr_en_d;
  rd_tag_t [RD_LAT-1:0]    tag_q, tag_d;
  rd_tag_t                 tag_out;
  logic                    arb_en, g, oor, sel_we;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       sel_wdata;
  // Grants are suppressed while in reset so every output reads 0 immediately.
  assign arb_en = rst_n && state_q == IDLE && !clr_start;
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .a_req (a_req),
    .b_req (b_req),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );
  always_comb begin
    g           = a_gnt | b_gnt;
    sel_we      = b_gnt ? b_we : a_we;
    sel_addr    = b_gnt ? b_addr : a_addr;
    sel_wdata   = b_gnt ? b_wdata : a_wdata;
    oor         = sel_addr == '0 || sel_addr > ADDR_W'(MEM_DEPTH);
    state_d     = state_q;
    sweep_d     = sweep_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_en_d = 1'b0;
    mem_wr_en_d = 1'b0;
    // valid marks a read owed a response; oor marks an err pulse (reads and writes).
    tag_d = {tag_q[RD_LAT-2:0], rd_tag_t'{valid: g && !sel_we, port: b_gnt ? PORT_B : PORT_A, oor: g && oor}};
    case (state_q)
      IDLE:
        if (clr_start) begin
          state_d = CLEAR;
          sweep_d = ADDR_W'(1);
        end else if (g && !oor) begin
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_rd_en_d = !sel_we;
          mem_wr_en_d = sel_we;
        end
      CLEAR: begin
        mem_wr_en_d = 1'b1;
        mem_addr_d  = sweep_q;
        mem_wdata_d = INIT_VAL;
        sweep_d     = sweep_q + ADDR_W'(1);
        state_d     = sweep_q == ADDR_W'(MEM_DEPTH) ? DONE : CLEAR;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      sweep_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      tag_q       <= tag_d;
    end
  assign tag_out   = tag_q[RD_LAT-1];
  assign a_rvalid  = tag_out.valid && tag_out.port == PORT_A;
  assign b_rvalid  = tag_out.valid && tag_out.port == PORT_B;
  assign a_rdata   = a_rvalid && !tag_out.oor ? mem_rdata : '0;
  assign b_rdata   = b_rvalid && !tag_out.oor ? mem_rdata : '0;
  assign a_err     = tag_out.oor && tag_out.port == PORT_A;
  assign b_err     = tag_out.oor && tag_out.port == PORT_B;
  assign busy      = state_q == CLEAR;
  assign clr_done  = state_q == DONE;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_wr_en = mem_wr_en_q;
endmodule
